// File: rtl/systolic_pe.sv
// Weight-stationary systolic-array processing element: double-buffered weight,
// signed MAC on the partial-sum path with optional saturation and sticky overflow.
// ACC_W must be at least 2*DATA_W.
module systolic_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] w_in,
  input  logic                     w_load,
  input  logic                     w_swap,
  output logic signed [DATA_W-1:0] w_out,
  output logic                     w_swap_out,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic                     a_valid,
  output logic signed [DATA_W-1:0] a_out,
  output logic                     a_valid_out,
  input  logic signed [ACC_W-1:0]  ps_in,
  output logic signed [ACC_W-1:0]  ps_out,
  input  logic                     sat_en,
  input  logic                     clr_ovf,
  output logic                     ovf
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = ACC_W + 1;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [DATA_W-1:0] shadow;
  logic signed [DATA_W-1:0] active;

  logic signed [PROD_W-1:0] mul_a;
  logic signed [PROD_W-1:0] mul_b;
  logic signed [PROD_W-1:0] product;
  logic        [SUM_W-1:0]  sum;
  logic                     sum_ovf;
  logic        [ACC_W-1:0]  ps_next;

  // Operands are widened to the product width first so the multiply is
  // exactly PROD_W bits wide; the low PROD_W bits hold the full signed product.
  always_comb begin
    mul_a   = {{DATA_W{active[DATA_W-1]}}, active};
    mul_b   = {{DATA_W{a_in[DATA_W-1]}}, a_in};
    product = mul_a * mul_b;
    sum     = {{(SUM_W-PROD_W){product[PROD_W-1]}}, product}
            + {ps_in[ACC_W-1], ps_in};
    // The extra sum bit disagreeing with the ACC_W sign bit means the
    // result does not fit the partial-sum range.
    sum_ovf = a_valid & (sum[ACC_W] ^ sum[ACC_W-1]);
    ps_next = a_valid ? sum[ACC_W-1:0] : ps_in;
    if (sum_ovf && sat_en) begin
      ps_next = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values; this is what makes a load+swap move the old shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow      <= '0;
      active      <= '0;
      w_swap_out  <= 1'b0;
      a_out       <= '0;
      a_valid_out <= 1'b0;
      ps_out      <= '0;
      ovf         <= 1'b0;
    end else begin
      if (w_load) shadow <= w_in;
      if (w_swap) active <= shadow;
      w_swap_out  <= w_swap;
      a_out       <= a_in;
      a_valid_out <= a_valid;
      ps_out      <= ps_next;
      // Set has priority over clear so an overflow is never lost.
      if (sum_ovf)      ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

  assign w_out = shadow;

endmodule
